// File: rtl/wiegand_tx_scheduler.sv
// Frame queue and sequencer in front of the Wiegand output engine: buffers 26-bit
// frames, hands them to the engine one at a time and reports completion/errors.
module wiegand_tx_scheduler #(
   parameter int DEPTH          = 4,
   parameter int GAP_CYCLES     = 16,
   parameter int TIMEOUT_CYCLES = 65536
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [25:0]              push_data,
   input  logic                     flush,
   input  logic                     irq_clr,
   input  logic                     eng_done_n,
   output logic [25:0]              eng_data,
   output logic                     eng_en,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     busy,
   output logic                     irq,
   output logic                     overflow,
   output logic                     timeout_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam int GW = $clog2(GAP_CYCLES) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2,
      GAP  = 2'd3
   } state_t;

   state_t          state_r;
   logic [25:0]     mem_r [DEPTH];
   logic [AW-1:0]   wr_ptr_r;
   logic [AW-1:0]   rd_ptr_r;
   logic [CW-1:0]   count_r;
   logic            full_r;
   logic [25:0]     eng_data_r;
   logic            eng_en_r;
   logic            busy_r;
   logic [TW-1:0]   tmo_r;
   logic [GW-1:0]   gap_r;
   logic            irq_r;
   logic            overflow_r;
   logic            timeout_err_r;

   logic            pop_s;
   logic            full_s;
   logic            push_ok_s;
   logic            push_drop_s;
   logic            done_s;
   logic            tmo_hit_s;
   logic            send_exit_s;
   logic            irq_set_s;
   logic [CW-1:0]   count_nxt_s;

   // A pop in the same cycle frees a slot, so a push into a full queue during LOAD is kept.
   assign pop_s       = (state_r == LOAD);
   assign full_s      = (count_r == CW'(DEPTH));
   assign push_ok_s   = push & ~flush & (~full_s | pop_s);
   assign push_drop_s = push & ~flush & full_s & ~pop_s;
   assign done_s      = (state_r == SEND) & ~eng_done_n;
   assign tmo_hit_s   = (state_r == SEND) & eng_done_n & (tmo_r == TW'(TIMEOUT_CYCLES - 1));
   assign send_exit_s = done_s | tmo_hit_s;
   assign irq_set_s   = send_exit_s & (count_r == {CW{1'b0}}) & ~push_ok_s;

   // Next queue occupancy.
   always_comb begin
      count_nxt_s = count_r;
      if (flush) begin
         count_nxt_s = {CW{1'b0}};
      end else if (push_ok_s && !pop_s) begin
         count_nxt_s = count_r + CW'(1);
      end else if (!push_ok_s && pop_s) begin
         count_nxt_s = count_r - CW'(1);
      end else begin
         count_nxt_s = count_r;
      end
   end

   // Frame storage; contents need no reset since count gates every read.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   // Queue pointers, occupancy and full flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
         full_r   <= 1'b0;
      end else begin
         count_r <= count_nxt_s;
         full_r  <= (count_nxt_s == CW'(DEPTH));
         if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
         end else begin
            if (push_ok_s) begin
               wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
               rd_ptr_r <= rd_ptr_r + AW'(1);
            end
         end
      end
   end

   // Frame sequencer driving the engine interface.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= IDLE;
         eng_data_r <= 26'd0;
         eng_en_r   <= 1'b0;
         busy_r     <= 1'b0;
         tmo_r      <= {TW{1'b0}};
         gap_r      <= {GW{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if ((count_r != {CW{1'b0}}) && !flush) begin
                  state_r <= LOAD;
                  busy_r  <= 1'b1;
               end
            end
            LOAD: begin
               eng_data_r <= mem_r[rd_ptr_r];
               eng_en_r   <= 1'b1;
               tmo_r      <= {TW{1'b0}};
               state_r    <= SEND;
            end
            SEND: begin
               if (send_exit_s) begin
                  eng_en_r <= 1'b0;
                  gap_r    <= GW'(GAP_CYCLES - 1);
                  state_r  <= GAP;
               end else begin
                  tmo_r <= tmo_r + TW'(1);
               end
            end
            GAP: begin
               if (gap_r == {GW{1'b0}}) begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
               end else begin
                  gap_r <= gap_r - GW'(1);
               end
            end
            default: begin
               state_r  <= IDLE;
               eng_en_r <= 1'b0;
               busy_r   <= 1'b0;
            end
         endcase
      end
   end

   // Sticky status flags; a set wins over a clear in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq_r         <= 1'b0;
         overflow_r    <= 1'b0;
         timeout_err_r <= 1'b0;
      end else begin
         irq_r         <= irq_set_s   | (irq_r & ~irq_clr);
         overflow_r    <= push_drop_s | (overflow_r & ~irq_clr);
         timeout_err_r <= tmo_hit_s   | (timeout_err_r & ~irq_clr);
      end
   end

   assign eng_data    = eng_data_r;
   assign eng_en      = eng_en_r;
   assign full        = full_r;
   assign count       = count_r;
   assign busy        = busy_r;
   assign irq         = irq_r;
   assign overflow    = overflow_r;
   assign timeout_err = timeout_err_r;

endmodule

// File: doc/wiegand_tx_scheduler.md
Name: wiegand_tx_scheduler

Overview:
Queues 26-bit Wiegand output frames written by the DSP bus interface and sequences them one at a time into the Wiegand output engine.
- Drives the engine's data word and level-sensitive enable.
- Waits for the engine's active-low completion strobe, then enforces a minimum inter-frame gap.
- Flags completion, overflow and engine timeout to the interrupt/status logic.
- Sits between the bus register file and the Wiegand output engine; replaces direct CPU toggling of the output-enable bit.

Parameters:
DEPTH, 4, frame queue depth in entries (power of two, 2..16)
GAP_CYCLES, 16, idle clk cycles between end of one frame and enable of the next (>=1)
TIMEOUT_CYCLES, 65536, max clk cycles eng_en may stay high without eng_done_n asserting (>=2)

Ports:
clk  input  1  system clock, all logic rising-edge
rst  input  1  asynchronous active-high reset
push  input  1  enqueue request, one frame per cycle high
push_data  input  26  frame to enqueue
flush  input  1  discard all queued (not in-flight) frames
irq_clr  input  1  clears irq, overflow, timeout_err
eng_done_n  input  1  engine completion strobe, active-low, synchronous to clk
eng_data  output  26  frame presented to engine
eng_en  output  1  engine enable, level
full  output  1  queue full
count  output  $clog2(DEPTH)+1  queued entries, excludes in-flight frame
busy  output  1  state != IDLE
irq  output  1  sticky: frame completed and queue empty
overflow  output  1  sticky: push while full was dropped
timeout_err  output  1  sticky: engine timeout occurred

Behaviour:
- Reset: all outputs 0, queue empty, state IDLE, count 0; eng_en drops asynchronously, aborting any frame.
- Queue: circular buffer with read/write pointers and separate count.
  - Pointers wrap modulo DEPTH.
  - full = (count == DEPTH).
- Push while not full: the entry is written and count increments next cycle.
- Push while full: data is dropped, count is unchanged, overflow is set. A push in the same cycle as a pop while full is accepted.
- Flush: count and pointers reset next cycle.
  - A push in the flush cycle is discarded and does not set overflow.
  - The in-flight frame is not affected.
- States: IDLE, LOAD, SEND, GAP.
- IDLE: if count != 0 and flush == 0, go to LOAD.
- LOAD (1 cycle):
  - eng_data <= head entry; pop (count decrements).
  - Go to SEND.
- SEND:
  - eng_en = 1 from the first SEND cycle; eng_data is stable throughout.
  - Timeout counter starts at 0 on entry and increments each cycle.
  - If eng_done_n == 0: eng_en <= 0 and go to GAP.
  - Else if the counter reaches TIMEOUT_CYCLES-1: eng_en <= 0, timeout_err <= 1, go to GAP.
  - eng_done_n is ignored outside SEND.
- GAP:
  - Gap counter loads GAP_CYCLES-1 on entry and decrements to 0, then goes to IDLE.
  - eng_en stays 0 for at least GAP_CYCLES cycles.
- Latency: push into an empty idle block → eng_en high 3 cycles later.
  - Cycle 1: entry written.
  - Cycle 2: LOAD.
  - Cycle 3: SEND.
- irq is set on the cycle SEND exits (done or timeout) if count == 0 and no push is accepted that cycle.
  - Set has priority over irq_clr in the same cycle.
  - The same set/clear priority applies to overflow and timeout_err.
- eng_data holds its last value after the frame; it is 0 only after reset.
- busy is high in LOAD, SEND and GAP.

Test Plan:
- Reset, then push 26'h2AAAAAA → eng_data = 26'h2AAAAAA at LOAD; eng_en rises 3 cycles after push.
  - Drive eng_done_n low for 1 cycle at SEND cycle 10 → eng_en 0 next cycle.
  - GAP lasts 16 cycles, then busy = 0 and irq = 1.
- Push 5 frames back-to-back into idle DEPTH=4 with the engine stalled.
  - First frame enters LOAD, so all 5 are accepted; count = 4, full = 1.
  - 6th push → overflow = 1, count stays 4.
  - Completing each frame sends the 5 frames in FIFO order with 16-cycle gaps.
- Queue 3 frames, assert flush during SEND of frame 1 → count = 0 next cycle; frame 1 still completes; irq = 1 after its done.
- Hold eng_done_n high with TIMEOUT_CYCLES = 32 → eng_en falls after exactly 32 high cycles, timeout_err = 1, the next queued frame starts after the gap.
- Assert irq_clr in the same cycle irq is set → irq = 1. Assert irq_clr a cycle later → irq, overflow and timeout_err all 0.
- Assert rst mid-SEND → eng_en 0 without waiting for clk.
  - After release, count = 0 and state is IDLE.
  - A new push gives eng_en 3 cycles later.
